// File: rtl/muladd_acc_pkg.sv
// Shared definitions for the multiply-accumulate unit: opcodes, control FSM encoding, pipeline depth.
package muladd_acc_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MACC = 2'b01;
  localparam logic [1:0] OP_MSUB = 2'b10;
  localparam logic [1:0] OP_MNEG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Cycles from operand sample to accumulator update; first is delayed PIPE_LAT-1 to match.
  localparam int PIPE_LAT = 3;

endpackage

// File: rtl/muladd_acc_ctrl.sv
// Run control: start delay, period/iteration counting, done flag, and the accumulator-restart
// marker (first) delayed to line up with the product stage.
module muladd_acc_ctrl
  import muladd_acc_pkg::*;
#(
  parameter int ITER_W   = 10,
  parameter int PERIOD_W = 10,
  parameter int DELAY_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [ITER_W-1:0]   iterations,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DELAY_W-1:0]  delay0,
  output logic                done,
  output logic                first_d2
);

  state_t                state;
  logic [DELAY_W-1:0]    dcnt;
  logic [PERIOD_W-1:0]   pcnt;
  logic [ITER_W-1:0]     icnt;
  logic [PERIOD_W-1:0]   plen;
  logic [PERIOD_W:0]     pnext;
  logic [ITER_W:0]       inext;
  logic                  first;
  logic [PIPE_LAT-2:0]   first_sr;

  assign plen  = (period == '0) ? PERIOD_W'(1) : period;
  assign pnext = {1'b0, pcnt} + (PERIOD_W+1)'(1);
  assign inext = {1'b0, icnt} + (ITER_W+1)'(1);
  assign first = (state != ST_RUN) || (pcnt == '0);
  assign first_d2 = first_sr[PIPE_LAT-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dcnt     <= '0;
      pcnt     <= '0;
      icnt     <= '0;
      done     <= 1'b0;
      first_sr <= '0;
    end else begin
      first_sr <= {first_sr[PIPE_LAT-3:0], first};
      if (run) begin
        state <= ST_DELAY;
        dcnt  <= delay0 + DELAY_W'(2);
        pcnt  <= '0;
        icnt  <= '0;
        done  <= 1'b0;
      end else begin
        case (state)
          ST_DELAY: begin
            // Leave DELAY on the edge where the count reaches zero.
            if (dcnt <= DELAY_W'(1)) begin
              dcnt <= '0;
              if (iterations == '0) begin
                state <= ST_FIN;
                done  <= 1'b1;
              end else begin
                state <= ST_RUN;
              end
            end else begin
              dcnt <= dcnt - DELAY_W'(1);
            end
          end
          ST_RUN: begin
            if (pnext >= {1'b0, plen}) begin
              pcnt <= '0;
              icnt <= inext[ITER_W-1:0];
              if (inext >= {1'b0, iterations}) begin
                state <= ST_FIN;
                done  <= 1'b1;
              end
            end else begin
              pcnt <= pnext[PERIOD_W-1:0];
            end
          end
          ST_IDLE: ;
          ST_FIN:  ;
        endcase
      end
    end
  end

endmodule

// File: rtl/muladd_acc.sv
// Signed multiply-accumulate unit: S1 operand regs, S2 product, S3 accumulator; out0 latency 3.
// Define MULADD_ACC_SAT_EN to clamp out0 to DATA_W and raise a sticky ovf flag.
module muladd_acc
  import muladd_acc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 64,
  parameter int ITER_W   = 10,
  parameter int PERIOD_W = 10,
  parameter int DELAY_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic                done,
  input  logic [DATA_W-1:0]   in0,
  input  logic [DATA_W-1:0]   in1,
  output logic [DATA_W-1:0]   out0,
  output logic                ovf,
  input  logic [1:0]          opcode,
  input  logic [ITER_W-1:0]   iterations,
  input  logic [PERIOD_W-1:0] period,
  input  logic [5:0]          shift,
  input  logic [DELAY_W-1:0]  delay0
);

  logic signed [DATA_W-1:0]   in0_r, in1_r;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, acc;
  logic                       first_d2;
  logic                       sh_fill;

  muladd_acc_ctrl #(
    .ITER_W   (ITER_W),
    .PERIOD_W (PERIOD_W),
    .DELAY_W  (DELAY_W)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .iterations (iterations),
    .period     (period),
    .delay0     (delay0),
    .done       (done),
    .first_d2   (first_d2)
  );

  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in0_r <= '0;
      in1_r <= '0;
      prod  <= '0;
      acc   <= '0;
    end else begin
      in0_r <= $signed(in0);
      in1_r <= $signed(in1);
      prod  <= (2*DATA_W)'(in0_r) * (2*DATA_W)'(in1_r);
      case (opcode)
        OP_MUL:          acc <= prod_ext;
        OP_MACC:         acc <= first_d2 ? prod_ext : acc + prod_ext;
        OP_MSUB, OP_MNEG: acc <= first_d2 ? -prod_ext : acc - prod_ext;
      endcase
    end
  end

  // Shifts at or beyond the accumulator width collapse to the sign bit.
  assign sh_fill = ({26'd0, shift} >= 32'(ACC_W));

`ifdef MULADD_ACC_SAT_EN
  logic signed [ACC_W-1:0] acc_sh;
  logic [ACC_W-DATA_W:0]   upper;
  logic                    sat_hi, sat_lo;

  assign acc_sh = sh_fill ? $signed({ACC_W{acc[ACC_W-1]}}) : (acc >>> shift);
  assign upper  = acc_sh[ACC_W-1:DATA_W-1];
  assign sat_hi = ~upper[ACC_W-DATA_W] & (|upper);
  assign sat_lo = upper[ACC_W-DATA_W] & ~(&upper);
  assign out0   = sat_hi ? {1'b0, {(DATA_W-1){1'b1}}} :
                  sat_lo ? {1'b1, {(DATA_W-1){1'b0}}} : acc_sh[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ovf <= 1'b0;
    else if (run)             ovf <= 1'b0;
    else if (sat_hi | sat_lo) ovf <= 1'b1;
  end
`else
  assign out0 = DATA_W'(sh_fill ? $signed({ACC_W{acc[ACC_W-1]}}) : (acc >>> shift));
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_muladd_acc.sv
// Bench for muladd_acc: schedule-level reference model checked every cycle, plus directed literal checks.
module tb_muladd_acc;

`ifdef MULADD_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst, run, done, ovf;
  logic signed [31:0] in0, in1;
  logic [31:0]        out0;
  logic [1:0]         opcode;
  logic [9:0]         iterations, period;
  logic [5:0]         shift;
  logic [31:0]        delay0;

  logic               run_b, done_b, ovf_b;
  logic [15:0]        in0_b, in1_b, out0_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  muladd_acc dut (
    .clk(clk), .rst(rst), .run(run), .done(done), .in0(in0), .in1(in1), .out0(out0),
    .ovf(ovf), .opcode(opcode), .iterations(iterations), .period(period),
    .shift(shift), .delay0(delay0)
  );

  muladd_acc #(.DATA_W(16), .ACC_W(32)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .done(done_b), .in0(in0_b), .in1(in1_b), .out0(out0_b),
    .ovf(ovf_b), .opcode(2'b01), .iterations(10'd1), .period(10'd2),
    .shift(6'd0), .delay0(32'd0)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int                 edge_n = 0;
  bit                 s_act = 1'b0;
  int                 s_e0 = 0, s_d = 0, s_p = 1, s_i = 0, s_done_edge = 0;
  logic signed [31:0] sa [64];
  logic signed [31:0] sb [64];
  bit                 sf [64];
  logic signed [63:0] m_acc = '0;
  bit                 m_done = 1'b0, m_ovf = 1'b0;

  // {clamped, out0} for a given accumulator value and shift
  function automatic logic [32:0] shaped(input logic signed [63:0] a, input logic [5:0] s);
    logic signed [63:0] v;
    v = a >>> s;
    if (SAT && v > 64'sh0000_0000_7FFF_FFFF) return {1'b1, 32'h7FFF_FFFF};
    if (SAT && v < -64'sh0000_0000_8000_0000) return {1'b1, 32'h8000_0000};
    return {1'b0, v[31:0]};
  endfunction

  always @(posedge rst) begin
    m_acc = '0; m_done = 1'b0; m_ovf = 1'b0; s_act = 1'b0;
    for (int k = 0; k < 64; k++) begin sa[k] = '0; sb[k] = '0; sf[k] = 1'b1; end
  end

  always @(posedge clk) begin
    int i, j, r0;
    bit f;
    logic [32:0] sh;
    logic signed [63:0] p;
    i = edge_n % 64;
    if (rst) begin
      sa[i] = '0; sb[i] = '0; sf[i] = 1'b1;
      m_acc = '0; m_done = 1'b0; m_ovf = 1'b0; s_act = 1'b0;
    end else begin
      sh = shaped(m_acc, shift);
      m_ovf = run ? 1'b0 : (m_ovf | sh[32]);
      // A sample restarts the sum unless it falls inside the RUN window off a period boundary.
      r0 = s_e0 + s_d + 3;
      f = !(s_act && s_i > 0 && edge_n >= r0 && edge_n < r0 + s_i * s_p) || ((edge_n - r0) % s_p == 0);
      sa[i] = in0; sb[i] = in1; sf[i] = f;
      if (edge_n >= 2) begin
        j = (edge_n - 2) % 64;
        p = 64'(sa[j]) * 64'(sb[j]);
        case (opcode)
          2'b00:   m_acc = p;
          2'b01:   m_acc = sf[j] ? p : m_acc + p;
          default: m_acc = sf[j] ? -p : m_acc - p;
        endcase
      end
      if (run) begin
        s_act = 1'b1; s_e0 = edge_n; s_d = int'(delay0);
        s_p = (period == 10'd0) ? 1 : int'(period);
        s_i = int'(iterations);
        s_done_edge = (s_i == 0) ? s_e0 + s_d + 2 : s_e0 + s_d + 2 + s_i * s_p;
      end
      m_done = s_act && (edge_n >= s_done_edge);
    end
    edge_n++;
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst === 1'b0) begin
      e = shaped(m_acc, shift);
      check("cyc_out0", 64'(out0), 64'(e[31:0]));
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_ovf", 64'(ovf), 64'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    run = 1'b1; step(); run = 1'b0;
  endtask

  task automatic pulse_run_b();
    run_b = 1'b1; step(); run_b = 1'b0;
  endtask

  int t2_exp [4] = '{15, 30, 45, 15};
  int t3_exp [4] = '{0, 0, 'h300, 'h300};
  int cnt;

  initial begin
    rst = 1'b0; run = 1'b0; in0 = '0; in1 = '0; opcode = 2'b01;
    iterations = '0; period = '0; shift = '0; delay0 = '0;
    run_b = 1'b0; in0_b = '0; in1_b = '0;
    #1 rst = 1'b1;
    step(); step();
    check("rst_out0", 64'(out0), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_out0_b", 64'(out0_b), 64'd0);
    rst = 1'b0;
    step(); step(); step();

    // MACC, period 4, two iterations, in0 = 1..8, in1 = 2
    opcode = 2'b01; period = 10'd4; iterations = 10'd2; delay0 = 32'd0; in1 = 32'sd2; in0 = '0;
    pulse_run();
    step(); step();
    for (int k = 1; k <= 8; k++) begin
      in0 = k;
      step();
      if (k == 6) check("t1_sum_first4", 64'(out0), 64'd20);
      if (k == 7) check("t1_done_early", 64'(done), 64'd0);
    end
    check("t1_done", 64'(done), 64'd1);
    step(); step();
    check("t1_sum_next4", 64'(out0), 64'd52);

    // MSUB, period 3, constant 5 * -3
    opcode = 2'b10; period = 10'd3; in0 = 32'sd5; in1 = -32'sd3;
    step(); step(); step();
    pulse_run();
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2_msub_seq", 64'(out0), 64'(t2_exp[k]));
    end

    // MUL with shift 4, latency from an input change
    opcode = 2'b00; shift = 6'd4; in0 = '0; in1 = '0;
    step(); step(); step();
    in0 = 32'sh100; in1 = 32'sh30;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_mul_shift", 64'(out0), 64'(t3_exp[k]));
    end
    shift = 6'd0;

    // iterations = 0 with a 5-cycle start delay
    opcode = 2'b01; iterations = 10'd0; delay0 = 32'd5;
    pulse_run();
    check("t4_done_cleared", 64'(done), 64'd0);
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin step(); cnt++; end
    check("t4_done_latency", 64'(cnt), 64'd7);

    // run re-asserted in the middle of RUN
    iterations = 10'd2; period = 10'd4; delay0 = 32'd0; in0 = 32'sd1; in1 = 32'sd1;
    pulse_run();
    repeat (4) step();
    pulse_run();
    check("t4b_done_low", 64'(done), 64'd0);
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin step(); cnt++; end
    check("t4b_restart_latency", 64'(cnt), 64'd10);

    // 16-bit unit: two 0x7FFF*0x7FFF accumulations
    in0_b = 16'h7FFF; in1_b = 16'h7FFF;
    pulse_run_b();
    repeat (5) step();
    check("t5_out_1", 64'(out0_b), SAT ? 64'h7FFF : 64'h0001);
    step();
    check("t5_out_2", 64'(out0_b), SAT ? 64'h7FFF : 64'h0002);
    check("t5_ovf_set", 64'(ovf_b), SAT ? 64'd1 : 64'd0);
    pulse_run_b();
    check("t5_ovf_run_clear", 64'(ovf_b), 64'd0);
    step();
    check("t5_ovf_resticky", 64'(ovf_b), SAT ? 64'd1 : 64'd0);

    // asynchronous reset during RUN
    opcode = 2'b01; in0 = 32'sd3; in1 = 32'sd7;
    pulse_run();
    repeat (7) step();
    check("t6_pre_rst", 64'(out0), 64'd63);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_out0", 64'(out0), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_ovf", 64'(ovf), 64'd0);
    step(); step();
    rst = 1'b0;
    repeat (12) step();
    check("t6_idle_done", 64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
